// File: rtl/voice_allocator_if.sv
// Message strobe/bus and voice-state outputs between keyboard scanner, allocator and tone generators.
// Purely structural: no storage, no latency.
// Backpressure: none; the allocator buffers messages and flags overflow itself.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic                      msg_stb;
  logic [7:0]                msg;
  logic [7*NUM_VOICES-1:0]   voice_note;
  logic [NUM_VOICES-1:0]     voice_on;
  logic [NUM_VOICES-1:0]     voice_upd;
  logic                      busy;
  logic                      fifo_ovf;
  logic [7:0]                drop_cnt;

  // Scanner side: issues messages, observes voice state.
  modport master (
    output msg_stb, msg,
    input  voice_note, voice_on, voice_upd, busy, fifo_ovf, drop_cnt
  );

  // Allocator side.
  modport slave (
    input  msg_stb, msg,
    output voice_note, voice_on, voice_upd, busy, fifo_ovf, drop_cnt
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: buffers note on/off messages and maps them onto NUM_VOICES channels.
// Latency: NUM_VOICES+2 cycles per message from FIFO pop to voice_upd pulse.
// Backpressure: none; a message arriving at a full FIFO is lost and fifo_ovf sticks high.
// Build option: VOICE_STEAL_EN makes a note-on with no free voice steal the oldest one.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_W      = 8
) (
  input  logic           clk_scan_13x,
  input  logic           rst,
  voice_allocator_if.slave bus
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t state_q, state_d;

  logic                 stb_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       cnt_q;
  logic                 fifo_ovf_q;
  logic                 push, pop, empty, full, push_ok;

  logic [7:0]           cur_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 match_vld_q, free_vld_q;
  logic [IDX_W-1:0]     match_idx_q, free_idx_q;
  logic                 scan_last, commit;

  logic [6:0]           note_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] on_q, upd_q;
  logic [7:0]           drop_q;

  logic                 start, release_v, set_note, drop;
  logic [IDX_W-1:0]     tgt;

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0]     age_q [NUM_VOICES];
  logic                 old_vld_q;
  logic [IDX_W-1:0]     old_idx_q;
  logic [AGE_W-1:0]     old_age_q;
`endif

  // Only a rising strobe edge enqueues; a held strobe counts once.
  assign push    = bus.msg_stb && !stb_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);

  // FSM state register.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one voice examined per SCAN cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty)   state_d = S_SCAN;
      S_SCAN:   if (scan_last) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    pop       = (state_q == S_IDLE) && !empty;
    scan_last = (state_q == S_SCAN) && (idx_q == LAST_IDX);
    commit    = (state_q == S_COMMIT);
  end

  // FIFO pointers, fill level, strobe edge register and sticky overflow flag.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      stb_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      fifo_ovf_q <= 1'b0;
    end else begin
      stb_q <= bus.msg_stb;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
      if (push && full && !pop) fifo_ovf_q <= 1'b1;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty, so no reset.
  always_ff @(posedge clk_scan_13x) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.msg;
  end

  // Scan trackers: match, lowest free voice and (when stealing) the oldest active voice.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      cur_q       <= '0;
      idx_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
`ifdef VOICE_STEAL_EN
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
`endif
    end else if (pop) begin
      cur_q       <= mem_q[rd_ptr_q];
      idx_q       <= '0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
`ifdef VOICE_STEAL_EN
      old_vld_q   <= 1'b0;
`endif
    end else if (state_q == S_SCAN) begin
      idx_q <= idx_q + 1'b1;
      if (on_q[idx_q] && note_q[idx_q] == cur_q[6:0] && !match_vld_q) begin
        match_vld_q <= 1'b1;
        match_idx_q <= idx_q;
      end
      if (!on_q[idx_q] && !free_vld_q) begin
        free_vld_q <= 1'b1;
        free_idx_q <= idx_q;
      end
`ifdef VOICE_STEAL_EN
      // Strict compare keeps the lowest index on an age tie.
      if (on_q[idx_q] && (!old_vld_q || age_q[idx_q] > old_age_q)) begin
        old_vld_q <= 1'b1;
        old_idx_q <= idx_q;
        old_age_q <= age_q[idx_q];
      end
`endif
    end
  end

  // Commit decision from the completed scan.
  always_comb begin
    start     = 1'b0;
    release_v = 1'b0;
    set_note  = 1'b0;
    drop      = 1'b0;
    tgt       = '0;
    if (commit) begin
      if (cur_q[7]) begin
        if (match_vld_q) begin
          start = 1'b1;
          tgt   = match_idx_q;
        end else if (free_vld_q) begin
          start    = 1'b1;
          set_note = 1'b1;
          tgt      = free_idx_q;
        end else begin
`ifdef VOICE_STEAL_EN
          start    = 1'b1;
          set_note = 1'b1;
          tgt      = old_idx_q;
`else
          drop     = 1'b1;
`endif
        end
      end else if (match_vld_q) begin
        release_v = 1'b1;
        tgt       = match_idx_q;
      end
    end
  end

  // Voice state, ages, update pulse and refused-note counter; all change only on COMMIT.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      on_q   <= '0;
      upd_q  <= '0;
      drop_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
`ifdef VOICE_STEAL_EN
        age_q[v]  <= '0;
`endif
      end
    end else begin
      upd_q <= '0;
      if (start || release_v) upd_q[tgt] <= 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (start && tgt == IDX_W'(v)) begin
          on_q[v] <= 1'b1;
          if (set_note) note_q[v] <= cur_q[6:0];
`ifdef VOICE_STEAL_EN
          age_q[v] <= '0;
        end else if (start && on_q[v] && age_q[v] != '1) begin
          age_q[v] <= age_q[v] + 1'b1;
`endif
        end
        if (release_v && tgt == IDX_W'(v)) on_q[v] <= 1'b0;
      end
    end
  end

  // Flatten per-voice notes onto the output bus.
  always_comb begin
    bus.voice_note = '0;
    for (int v = 0; v < NUM_VOICES; v++) bus.voice_note[7*v +: 7] = note_q[v];
  end

  assign bus.voice_on  = on_q;
  assign bus.voice_upd = upd_q;
  assign bus.busy      = (state_q != S_IDLE) || !empty;
  assign bus.fifo_ovf  = fifo_ovf_q;
  assign bus.drop_cnt  = drop_q;

endmodule
